// File: rtl/matmul_sched_pkg.sv
// Shared types and constants for the 2x2 matmul job scheduler.
// Holds state encodings, response status codes, operand widths and a reject helper.
package matmul_sched_pkg;

    localparam int ELEM_W     = 4;
    localparam int MAT_W      = 16;
    localparam int RES_ELEM_W = 8;
    localparam int RES_W      = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_REJECT  = 2'b10;

    // A matrix packed {x00,x01,x10,x11}: top byte is row 0, bottom byte row 1.
    function automatic logic has_zero_row(input logic [MAT_W-1:0] m);
        return (m[MAT_W-1 -: 2*ELEM_W] == '0) || (m[2*ELEM_W-1:0] == '0);
    endfunction

endpackage

// File: rtl/matmul_sched_rr_arb2.sv
// Two-requester round-robin arbiter with its own pointer register.
// Ports: clk, rst_n, en (arbitration allowed), req[1:0] in; gnt[1:0] out.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = ptr_q ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
        // Every grant is an acceptance, so hand priority to the other side.
        ptr_d = ptr_q;
        if (|gnt) begin
            ptr_d = gnt[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/matmul_sched.sv
// Schedules 2x2 matmul jobs from two requesters onto one engine, one at a time.
// Ports: req0/1 valid/ready/a/b in, eng_start/a/b out, eng_done/c in, rsp_* out, busy, state_dbg.
module matmul_sched
    import matmul_sched_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [MAT_W-1:0] req0_a,
    input  logic [MAT_W-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [MAT_W-1:0] req1_a,
    input  logic [MAT_W-1:0] req1_b,
    output logic             eng_start,
    output logic [MAT_W-1:0] eng_a,
    output logic [MAT_W-1:0] eng_b,
    input  logic             eng_done,
    input  logic [RES_W-1:0] eng_c,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [RES_W-1:0] rsp_c,
    output logic [1:0]       rsp_err,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] WAIT  = ST_WAIT;
    localparam logic [1:0] RESP  = ST_RESP;

    localparam int              CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MAT_W-1:0] a_q, a_d;
    logic [MAT_W-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [RES_W-1:0] rsp_c_q, rsp_c_d;
    logic [1:0]       rsp_err_q, rsp_err_d;
    logic             eng_start_q, eng_start_d;
    logic             busy_q, busy_d;

    logic [1:0]       gnt;
    logic [MAT_W-1:0] sel_a;
    logic [MAT_W-1:0] sel_b;
    logic             op_live;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == IDLE),
        .req   ({req1_valid, req0_valid}),
        .gnt   (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    assign sel_a = gnt[1] ? req1_a : req0_a;
    assign sel_b = gnt[1] ? req1_b : req0_b;

    // Operands are only presented while the engine owns the job.
    assign op_live = (state_q == ISSUE) || (state_q == WAIT);
    assign eng_a   = op_live ? a_q : '0;
    assign eng_b   = op_live ? b_q : '0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        rsp_id_d  = rsp_id_q;
        rsp_c_d   = rsp_c_q;
        rsp_err_d = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    a_d  = sel_a;
                    b_d  = sel_b;
                    id_d = gnt[1];
                    if (has_zero_row(sel_a) || has_zero_row(sel_b)) begin
                        state_d   = RESP;
                        rsp_id_d  = gnt[1];
                        rsp_c_d   = '0;
                        rsp_err_d = ERR_REJECT;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // Done is tested first so it wins a tie with the timeout.
                if (eng_done) begin
                    state_d   = RESP;
                    rsp_id_d  = id_q;
                    rsp_c_d   = eng_c;
                    rsp_err_d = ERR_OK;
                end else if (cnt_q == LAST) begin
                    state_d   = RESP;
                    rsp_id_d  = id_q;
                    rsp_c_d   = '0;
                    rsp_err_d = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d   = IDLE;
                    rsp_id_d  = 1'b0;
                    rsp_c_d   = '0;
                    rsp_err_d = ERR_OK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered status outputs follow the next state.
        rsp_valid_d = (state_d == RESP);
        eng_start_d = (state_d == ISSUE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_c_q     <= '0;
            rsp_err_q   <= ERR_OK;
            eng_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_c_q     <= rsp_c_d;
            rsp_err_q   <= rsp_err_d;
            eng_start_q <= eng_start_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_err   = rsp_err_q;
    assign eng_start = eng_start_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_matmul_sched.sv
// Testbench for matmul_sched: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model of the scheduler.
module tb_matmul_sched;
    import matmul_sched_pkg::*;

    localparam int TO = 32;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        eng_start;
    logic [15:0] eng_a, eng_b;
    logic        eng_done;
    logic [31:0] eng_c;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_c;
    logic [1:0]  rsp_err;
    logic        busy;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    matmul_sched #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b),
        .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
        .eng_done(eng_done), .eng_c(eng_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_c(rsp_c), .rsp_err(rsp_err),
        .busy(busy), .state_dbg(state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int elem(input logic [15:0] m, input int r, input int c);
        logic [15:0] t;
        t = m >> (4 * (3 - (2 * r + c)));
        return int'(t[3:0]);
    endfunction

    function automatic logic [31:0] matmul(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] r;
        int v;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                v = elem(a, i, 0) * elem(b, 0, j) + elem(a, i, 1) * elem(b, 1, j);
                r = r | (32'(v & 255) << (8 * (3 - (2 * i + j))));
            end
        end
        return r;
    endfunction

    function automatic bit rejected(input logic [15:0] a, input logic [15:0] b);
        bit z;
        z = 0;
        for (int r = 0; r < 2; r++) begin
            if (elem(a, r, 0) == 0 && elem(a, r, 1) == 0) z = 1;
            if (elem(b, r, 0) == 0 && elem(b, r, 1) == 0) z = 1;
        end
        return z;
    endfunction

    function automatic logic [15:0] rnd_mat();
        logic [15:0] m;
        m = 16'($urandom);
        if ($urandom % 5 == 0) begin
            if ($urandom % 2 == 0) m[15:8] = '0;
            else m[7:0] = '0;
        end
        return m;
    endfunction

    // ---------------- engine model ----------------
    int          eng_delay = 0;
    bit          rand_mode = 0;
    bit          c_ovr_en = 0;
    logic [31:0] c_ovr = '0;

    initial begin : engine
        bit          armed;
        int          cnt;
        logic [31:0] pend;
        armed = 0;
        cnt = 0;
        pend = '0;
        eng_done = 1'b0;
        eng_c = '0;
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1) begin
                pend = c_ovr_en ? c_ovr : matmul(eng_a, eng_b);
                if (rand_mode) begin
                    armed = ($urandom % 6) != 0;
                    cnt = $urandom_range(0, 34);
                end else begin
                    armed = eng_delay >= 0;
                    cnt = eng_delay;
                end
            end
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            eng_c = $urandom;
            if (armed) begin
                if (cnt == 0) begin
                    eng_done = 1'b1;
                    eng_c = pend;
                    armed = 0;
                end else begin
                    cnt--;
                end
            end
            if (rand_mode && !eng_done && ($urandom % 40) == 0) eng_done = 1'b1;
        end
    end

    // ---------------- transaction model + per-cycle compare ----------------
    bit          m_busy, m_start_due, m_waiting, m_rsp, m_ptr, m_id;
    int          m_wcnt;
    logic [15:0] m_a, m_b;
    logic [31:0] m_c;
    logic [1:0]  m_err;

    int          n_starts = 0, n_done = 0;
    int          acc_cyc = 0, start_cyc = 0, rsp_cyc = 0;
    logic [31:0] last_c;
    logic [1:0]  last_err;
    logic        last_id;
    bit          prev_rv = 0;
    int          grants[$];

    always @(negedge clk) begin : compare
        bit er0, er1;
        if (!rst_n) begin
            m_busy = 0; m_start_due = 0; m_waiting = 0; m_rsp = 0;
            m_ptr = 0; m_wcnt = 0;
            prev_rv = 0;
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_eng_start", eng_start, 0);
            chk("rst_state", state_dbg, 0);
            chk("rst_rsp_c", rsp_c, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_eng_a", eng_a, 0);
            chk("rst_eng_b", eng_b, 0);
        end else begin
            er0 = !m_busy && req0_valid && (!req1_valid || !m_ptr);
            er1 = !m_busy && req1_valid && (!req0_valid || m_ptr);
            chk("req0_ready", req0_ready, er0);
            chk("req1_ready", req1_ready, er1);
            chk("busy", busy, m_busy);
            chk("eng_start", eng_start, m_start_due);
            chk("eng_a", eng_a, (m_start_due || m_waiting) ? m_a : 16'h0);
            chk("eng_b", eng_b, (m_start_due || m_waiting) ? m_b : 16'h0);
            chk("rsp_valid", rsp_valid, m_rsp);
            if (m_rsp) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_c", rsp_c, m_c);
                chk("rsp_err", rsp_err, m_err);
            end
            if (!m_busy) chk("state_idle", state_dbg, 0);

            if (eng_start) begin n_starts++; start_cyc = cyc; end
            if (eng_done) n_done++;
            if (req0_valid && req0_ready) begin grants.push_back(0); acc_cyc = cyc; end
            if (req1_valid && req1_ready) begin grants.push_back(1); acc_cyc = cyc; end
            if (rsp_valid && !prev_rv) begin
                rsp_cyc = cyc; last_c = rsp_c; last_err = rsp_err; last_id = rsp_id;
            end
            prev_rv = rsp_valid;

            if (m_rsp) begin
                if (rsp_ready) begin m_rsp = 0; m_busy = 0; end
            end else if (m_waiting) begin
                if (eng_done) begin
                    m_waiting = 0; m_rsp = 1; m_c = eng_c; m_err = 2'b00;
                end else begin
                    m_wcnt++;
                    if (m_wcnt == TO) begin
                        m_waiting = 0; m_rsp = 1; m_c = '0; m_err = 2'b01;
                    end
                end
            end else if (m_start_due) begin
                m_start_due = 0; m_waiting = 1; m_wcnt = 0;
            end else if (er0 || er1) begin
                m_id = er1;
                m_a = er1 ? req1_a : req0_a;
                m_b = er1 ? req1_b : req0_b;
                m_ptr = !er1;
                m_busy = 1;
                if (rejected(m_a, m_b)) begin
                    m_rsp = 1; m_c = '0; m_err = 2'b10;
                end else begin
                    m_start_due = 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
    endtask

    task automatic offer(input logic v0, input logic v1,
                         input logic [15:0] a0, input logic [15:0] b0,
                         input logic [15:0] a1, input logic [15:0] b1,
                         output int gid);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        gid = -1;
        for (int i = 0; i < 200 && gid < 0; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) gid = 0;
            else if (req1_valid && req1_ready) gid = 1;
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("offer_granted", gid >= 0, 1);
    endtask

    task automatic wait_handshake(input string nm);
        bit done;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = rsp_valid && rsp_ready;
            step();
        end
        chk(nm, done, 1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int gid, s0, g0, d0, bad;
        bit seen;
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Test 1: basic job, engine done after 12 cycles
        eng_delay = 11; c_ovr_en = 1; c_ovr = 32'h1314292E;
        offer(1, 0, 16'h1234, 16'h5678, 16'h0, 16'h0, gid);
        wait_handshake("t1_handshake");
        chk("t1_gid", gid, 0);
        chk("t1_start_lat", start_cyc - acc_cyc, 1);
        chk("t1_rsp_lat", rsp_cyc - start_cyc, 13);
        chk("t1_c", last_c, 32'h1314292E);
        chk("t1_err", last_err, 2'b00);
        chk("t1_id", last_id, 0);
        c_ovr_en = 0;

        // Test 2: both valid back to back after reset alternate 0,1,0,1
        do_reset();
        eng_delay = 1;
        g0 = grants.size();
        req0_valid = 1; req0_a = 16'h1111; req0_b = 16'h2222;
        req1_valid = 1; req1_a = 16'h3333; req1_b = 16'h4444;
        for (int i = 0; i < 400 && grants.size() < g0 + 4; i++) step();
        req0_valid = 0; req1_valid = 0;
        chk("t2_grant_count", grants.size() - g0 >= 4, 1);
        if (grants.size() >= g0 + 4) begin
            chk("t2_grant0", grants[g0], 0);
            chk("t2_grant1", grants[g0 + 1], 1);
            chk("t2_grant2", grants[g0 + 2], 0);
            chk("t2_grant3", grants[g0 + 3], 1);
        end
        wait_handshake("t2_last_handshake");

        // Test 3: zero row in A -> reject, no engine start
        s0 = n_starts;
        offer(0, 1, 16'h0, 16'h0, 16'h0034, 16'h1111, gid);
        wait_handshake("t3_handshake");
        chk("t3_err", last_err, 2'b10);
        chk("t3_c", last_c, 0);
        chk("t3_id", last_id, 1);
        chk("t3_lat", rsp_cyc - acc_cyc, 1);
        chk("t3_no_start", n_starts - s0, 0);

        // Test 4: engine never completes -> timeout
        eng_delay = -1;
        offer(1, 0, 16'h1212, 16'h3434, 16'h0, 16'h0, gid);
        wait_handshake("t4_handshake");
        chk("t4_err", last_err, 2'b01);
        chk("t4_c", last_c, 0);
        chk("t4_lat", rsp_cyc - start_cyc, TO + 1);

        // Done in the last allowed WAIT cycle beats the timeout
        eng_delay = TO - 1;
        offer(0, 1, 16'h0, 16'h0, 16'h1357, 16'h2468, gid);
        wait_handshake("t4b_handshake");
        chk("t4b_err", last_err, 2'b00);
        chk("t4b_c", last_c, matmul(16'h1357, 16'h2468));

        // Done one cycle too late is a timeout
        eng_delay = TO;
        offer(1, 0, 16'h1357, 16'h2468, 16'h0, 16'h0, gid);
        wait_handshake("t4c_handshake");
        chk("t4c_err", last_err, 2'b01);

        // Test 5: consumer stalls, new request must wait
        eng_delay = 3;
        rsp_ready = 1'b0;
        offer(1, 0, 16'h2143, 16'h1321, 16'h0, 16'h0, gid);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
            step();
        end
        chk("t5_rsp_seen", seen, 1);
        req1_valid = 1; req1_a = 16'h1122; req1_b = 16'h3344;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_req1_ready_low", req1_ready, 0);
            chk("t5_rsp_valid_hold", rsp_valid, 1);
            chk("t5_rsp_c_hold", rsp_c, matmul(16'h2143, 16'h1321));
            chk("t5_rsp_err_hold", rsp_err, 2'b00);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t5_handshake", rsp_valid, 1);
        step();
        @(negedge clk);
        chk("t5_idle_after", state_dbg, 0);
        chk("t5_req1_ready", req1_ready, 1);
        step();
        req1_valid = 0;
        wait_handshake("t5_second_handshake");

        // Test 6: reset during WAIT, late done afterwards is ignored
        eng_delay = 20;
        offer(1, 0, 16'h1234, 16'h4321, 16'h0, 16'h0, gid);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (state_dbg == 2'd2);
            step();
        end
        chk("t6_in_wait", seen, 1);
        repeat (4) step();
        d0 = n_done;
        #2;
        do_reset();
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid || busy || eng_start || state_dbg != 0) bad++;
            step();
        end
        chk("t6_stays_idle", bad, 0);
        chk("t6_late_done_seen", n_done - d0 >= 1, 1);
        offer(1, 1, 16'h1111, 16'h1111, 16'h2222, 16'h2222, gid);
        chk("t6_ptr_reset", gid, 0);
        wait_handshake("t6_handshake");

        // Randomized traffic
        rand_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            req0_valid = ($urandom % 3) == 0;
            req1_valid = ($urandom % 3) == 0;
            req0_a = rnd_mat(); req0_b = rnd_mat();
            req1_a = rnd_mat(); req1_b = rnd_mat();
            rsp_ready = ($urandom % 4) != 0;
            step();
        end
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        rand_mode = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = !busy;
            step();
        end
        chk("rand_drain", seen, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
